// File: rtl/gemm_pkg.sv
// Shared GEMM kernel parameters, address-width helper and the kernel sequencer state type.
package gemm_pkg;

    localparam int N_WI = 4;
    localparam int N_K  = 8;
    localparam int N_CT = 4;

    function automatic int aw(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    localparam int KR_AW = aw(N_WI * N_K);
    localparam int KP_AW = aw(N_K);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        FLUSH,
        FIN,
        DRAIN,
        DONE
    } kctrl_state_t;

endpackage

// File: rtl/kctrl_delay.sv
// Fixed-depth shift register with synchronous clear; aligns MAC controls with buffer read data.
module kctrl_delay
    import gemm_pkg::*;
#(
    parameter int W     = 2,
    parameter int DEPTH = 1
) (
    input  logic         clk,
    input  logic         clr,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);

    logic [W-1:0] pipe [DEPTH];

    always_ff @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < DEPTH; i++) pipe[i] <= '0;
        end else begin
            pipe[0] <= din;
            for (int i = 1; i < DEPTH; i++) pipe[i] <= pipe[i-1];
        end
    end

    assign dout = pipe[DEPTH-1];

endmodule

// File: rtl/kernel_ctrl.sv
// GEMM kernel sequencer: N_WI rows x N_K reduction steps, buffer reads, MAC controls, row/batch handshakes.
// Build option KCTRL_PERF_EN adds the perf_busy / perf_stall cycle counters.
//
// state | meaning
// IDLE  | waiting for s_init
// ISSUE | one source/param read per cycle, k = 0..N_K-1
// FLUSH | RD_LAT cycles while the last reads reach the MACs
// FIN   | k_fin pulse to out_ctrl
// DRAIN | waiting for out_ctrl to finish draining the row
// DONE  | s_fin pulse to batch_ctrl
module kernel_ctrl
    import gemm_pkg::*;
#(
    parameter int  N_WI   = gemm_pkg::N_WI,
    parameter int  N_K    = gemm_pkg::N_K,
    parameter int  RD_LAT = 1,
    localparam int KR_W   = aw(N_WI * N_K),
    localparam int KP_W   = aw(N_K)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            run,
    input  logic            s_init,
    input  logic            out_busy,
    output logic [KR_W-1:0] kr_a,
    output logic [KP_W-1:0] kp_a,
    output logic            acc_clr,
    output logic            acc_en,
    output logic            k_fin,
    output logic            s_fin,
    output logic            busy,
    output logic            err
`ifdef KCTRL_PERF_EN
    ,
    output logic [31:0]     perf_busy,
    output logic [31:0]     perf_stall
`endif
);

    localparam int WI_W = aw(N_WI);
    localparam int FT_W = aw(RD_LAT);

    kctrl_state_t    state, state_nx;
    logic [KP_W-1:0] k, k_nx;
    logic [WI_W-1:0] wi, wi_nx;
    logic [FT_W-1:0] ft, ft_nx;
    logic            clr;
    logic            issue;
    logic            first;
    logic [1:0]      mac_dly;

    // run low behaves exactly like reset, including flushing in-flight MAC controls
    assign clr = reset | ~run;

    always_ff @(posedge clk) begin
        if (clr) begin
            state <= IDLE;
            k     <= '0;
            wi    <= '0;
            ft    <= '0;
            err   <= 1'b0;
        end else begin
            state <= state_nx;
            k     <= k_nx;
            wi    <= wi_nx;
            ft    <= ft_nx;
            if (s_init && state != IDLE) err <= 1'b1;
        end
    end

    always_comb begin
        state_nx = state;
        k_nx     = k;
        wi_nx    = wi;
        ft_nx    = ft;
        issue    = 1'b0;
        k_fin    = 1'b0;
        s_fin    = 1'b0;
        case (state)
            IDLE: begin
                if (s_init) begin
                    state_nx = ISSUE;
                    k_nx     = '0;
                    wi_nx    = '0;
                end
            end
            ISSUE: begin
                issue = 1'b1;
                if (k == KP_W'(N_K - 1)) begin
                    state_nx = FLUSH;
                    k_nx     = '0;
                    ft_nx    = FT_W'(RD_LAT - 1);
                end else begin
                    k_nx = k + 1'b1;
                end
            end
            FLUSH: begin
                if (ft == '0) state_nx = FIN;
                else          ft_nx    = ft - 1'b1;
            end
            FIN: begin
                k_fin    = 1'b1;
                state_nx = DRAIN;
            end
            DRAIN: begin
                if (!out_busy) begin
                    if (wi == WI_W'(N_WI - 1)) begin
                        state_nx = DONE;
                        wi_nx    = '0;
                    end else begin
                        state_nx = ISSUE;
                        wi_nx    = wi + 1'b1;
                    end
                end
            end
            DONE: begin
                s_fin    = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign busy  = (state != IDLE);
    assign first = issue && (k == '0);
    assign kr_a  = issue ? (KR_W'(wi) * KR_W'(N_K) + KR_W'(k)) : '0;
    assign kp_a  = issue ? k : '0;

    kctrl_delay #(
        .W     (2),
        .DEPTH (RD_LAT)
    ) u_dly (
        .clk  (clk),
        .clr  (clr),
        .din  ({issue, first}),
        .dout (mac_dly)
    );

    assign acc_en  = mac_dly[1];
    assign acc_clr = mac_dly[0];

`ifdef KCTRL_PERF_EN
    always_ff @(posedge clk) begin
        if (clr) begin
            perf_busy  <= '0;
            perf_stall <= '0;
        end else begin
            if (busy && perf_busy != '1)             perf_busy  <= perf_busy + 32'd1;
            if (state == DRAIN && perf_stall != '1)  perf_stall <= perf_stall + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_kernel_ctrl.sv
// Self-checking bench: two kernel_ctrl instances (RD_LAT 1 and 3) checked cycle by cycle against a schedule model.
module tb_kernel_ctrl;

    localparam int NW   = 4;
    localparam int NK   = 8;
    localparam int MAXC = 320;

    logic       clk = 1'b0;
    logic       reset, run, s_init;
    logic [1:0] ob;
    logic [4:0] kr_a [2];
    logic [2:0] kp_a [2];
    logic [1:0] acc_clr, acc_en, k_fin, s_fin, busy, err;
`ifdef KCTRL_PERF_EN
    logic [31:0] perf_busy  [2];
    logic [31:0] perf_stall [2];
`endif

    int n_chk  = 0;
    int n_fail = 0;

    int e_kra   [2][MAXC];
    int e_kpa   [2][MAXC];
    bit e_en    [2][MAXC];
    bit e_clr   [2][MAXC];
    bit e_kfin  [2][MAXC];
    bit e_sfin  [2][MAXC];
    bit e_busy  [2][MAXC];
    bit e_drain [2][MAXC];
    bit e_ob    [2][MAXC];
    int last    [2];
    int drn     [4];
    bit exp_err [2];
    int pb      [2];
    int ps      [2];

    always #5 clk = ~clk;

    kernel_ctrl #(.N_WI(NW), .N_K(NK), .RD_LAT(1)) dut1 (
        .clk(clk), .reset(reset), .run(run), .s_init(s_init), .out_busy(ob[0]),
        .kr_a(kr_a[0]), .kp_a(kp_a[0]), .acc_clr(acc_clr[0]), .acc_en(acc_en[0]),
        .k_fin(k_fin[0]), .s_fin(s_fin[0]), .busy(busy[0]), .err(err[0])
`ifdef KCTRL_PERF_EN
        , .perf_busy(perf_busy[0]), .perf_stall(perf_stall[0])
`endif
    );

    kernel_ctrl #(.N_WI(NW), .N_K(NK), .RD_LAT(3)) dut3 (
        .clk(clk), .reset(reset), .run(run), .s_init(s_init), .out_busy(ob[1]),
        .kr_a(kr_a[1]), .kp_a(kp_a[1]), .acc_clr(acc_clr[1]), .acc_en(acc_en[1]),
        .k_fin(k_fin[1]), .s_fin(s_fin[1]), .busy(busy[1]), .err(err[1])
`ifdef KCTRL_PERF_EN
        , .perf_busy(perf_busy[1]), .perf_stall(perf_stall[1])
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [13:0] obs_vec(input int j);
        return {busy[j], k_fin[j], s_fin[j], acc_en[j], acc_clr[j], err[j], kr_a[j], kp_a[j]};
    endfunction

    function automatic logic [13:0] exp_vec(input int j, input int c, input bit dead);
        if (dead) return {5'b0, exp_err[j], 8'b0};
        return {e_busy[j][c], e_kfin[j][c], e_sfin[j][c], e_en[j][c], e_clr[j][c],
                exp_err[j], 5'(e_kra[j][c]), 3'(e_kpa[j][c])};
    endfunction

    // Batch timeline, cycle 0 = s_init cycle: each row issues NK reads, MAC controls
    // follow rd cycles later, k_fin one cycle after the last MAC, then drain.
    task automatic build(input int j);
        int s, f, rd;
        rd = (j == 0) ? 1 : 3;
        for (int c = 0; c < MAXC; c++) begin
            e_kra[j][c] = 0;  e_kpa[j][c] = 0;  e_en[j][c] = 0;    e_clr[j][c] = 0;
            e_kfin[j][c] = 0; e_sfin[j][c] = 0; e_busy[j][c] = 0;  e_drain[j][c] = 0;
            e_ob[j][c] = 0;
        end
        s = 1;
        for (int r = 0; r < NW; r++) begin
            for (int k = 0; k < NK; k++) begin
                e_kra[j][s+k]  = r * NK + k;
                e_kpa[j][s+k]  = k;
                e_en[j][s+rd+k] = 1;
            end
            e_clr[j][s+rd] = 1;
            f = s + NK + rd;
            e_kfin[j][f] = 1;
            for (int c = s; c <= f; c++) e_busy[j][c] = 1;
            for (int c = 1; c <= drn[r]; c++) e_ob[j][f+c] = 1;
            for (int c = f + 1; c <= f + drn[r] + 1; c++) begin
                e_busy[j][c]  = 1;
                e_drain[j][c] = 1;
            end
            s = f + drn[r] + 2;
        end
        e_sfin[j][s] = 1;
        e_busy[j][s] = 1;
        last[j] = s;
    endtask

    // inj_c: cycle of an extra s_init (-1 none, -2 = DONE cycle of the RD_LAT=1 unit)
    task automatic run_batch(input int inj_c_in, input bit drop);
        int  stop, drop_c, inj_c;
        bit  dead, bz;
        build(0);
        build(1);
        inj_c  = (inj_c_in == -2) ? last[0] : inj_c_in;
        drop_c = -1;
        if (drop)
            for (int c = 0; c < MAXC; c++)
                if (e_busy[0][c] && e_kra[0][c] == 2 * NK + 5) drop_c = c;
        stop = ((last[0] > last[1]) ? last[0] : last[1]) + 1;
        if (drop_c >= 0) stop = drop_c + 1;
        for (int c = 0; c <= stop; c++) begin
            s_init = (c == 0) || (c == inj_c);
            run    = !(c == drop_c);
            ob[0]  = e_ob[0][c];
            ob[1]  = e_ob[1][c];
            @(negedge clk);
            dead = (drop_c >= 0) && (c > drop_c);
            for (int j = 0; j < 2; j++) begin
                check($sformatf("u%0d_c%0d", j, c), 32'(obs_vec(j)), 32'(exp_vec(j, c, dead)));
`ifdef KCTRL_PERF_EN
                check($sformatf("u%0d_pbusy_c%0d", j, c), perf_busy[j], pb[j]);
                check($sformatf("u%0d_pstall_c%0d", j, c), perf_stall[j], ps[j]);
`endif
                bz = !dead && e_busy[j][c];
                if (!run) begin
                    exp_err[j] = 0;
                    pb[j] = 0;
                    ps[j] = 0;
                end else begin
                    if (s_init && bz) exp_err[j] = 1;
                    pb[j] += bz ? 1 : 0;
                    ps[j] += (!dead && e_drain[j][c]) ? 1 : 0;
                end
            end
            @(posedge clk);
            #1;
        end
        s_init = 0;
        run    = 1;
        ob     = 2'b00;
    endtask

    task automatic rand_drn();
        for (int r = 0; r < 4; r++) drn[r] = $urandom_range(1, 6);
    endtask

    initial begin
        reset  = 1;
        run    = 1;
        s_init = 0;
        ob     = 2'b00;
        for (int j = 0; j < 2; j++) begin
            exp_err[j] = 0;
            pb[j] = 0;
            ps[j] = 0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int j = 0; j < 2; j++) check($sformatf("reset_u%0d", j), 32'(obs_vec(j)), 32'd0);
        @(posedge clk);
        #1;
        reset = 0;

        // defaults: 3 busy cycles after each k_fin gives a 4-cycle drain
        for (int r = 0; r < 4; r++) drn[r] = 3;
        run_batch(-1, 0);
`ifdef KCTRL_PERF_EN
        check("perf_busy_b1", perf_busy[0], 32'd57);
        check("perf_stall_b1", perf_stall[0], 32'd16);
`endif
        rand_drn();
        run_batch(3, 0);
        check("err_sticky_u0", 32'(err[0]), 32'd1);
        check("err_sticky_u1", 32'(err[1]), 32'd1);

        rand_drn();
        drn[0] = 20;
        run_batch(-1, 0);

        rand_drn();
        run_batch(-1, 1);
        check("err_cleared_u0", 32'(err[0]), 32'd0);

        rand_drn();
        run_batch(-1, 0);

        rand_drn();
        run_batch(-2, 0);

        for (int b = 0; b < 4; b++) begin
            rand_drn();
            run_batch((b == 1) ? 10 : -1, 0);
        end

        reset = 1;
        @(posedge clk);
        #1;
        reset = 0;
        @(negedge clk);
        for (int j = 0; j < 2; j++) check($sformatf("post_reset_u%0d", j), 32'(obs_vec(j)), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
